// File: rtl/magia_tile_pkg.sv
// Tile-level constants and OBI / iDMA register-frontend types used by the
// iDMA control multiplexer.
package magia_tile_pkg;

    localparam logic [31:0] IDMA_CTRL_ADDR_START = 32'h0002_0A00;
    localparam int unsigned OBI_AID_W            = 4;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 we;
        logic [3:0]           be;
        logic [31:0]          wdata;
        logic [OBI_AID_W-1:0] aid;
        logic [0:0]           a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0]          rdata;
        logic [OBI_AID_W-1:0] rid;
        logic                 err;
        logic [0:0]           r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } idma_fe_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } idma_fe_reg_rsp_t;

endpackage

// File: rtl/idma_obi_ctrl_mux.sv
// OBI-to-iDMA register frontend bridge. A CPU access in the control window is
// decoded into a channel index and a register offset, forwarded to the chosen
// reg32_3d frontend, and answered with a registered OBI response. Only one
// access is in flight at a time; unmapped offsets/channels answer with err=1.
// Optional feature macro: IDMA_OBI_CTRL_TIMEOUT_EN (frontend watchdog).
module idma_obi_ctrl_mux #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CH_SEL_OFF     = 8,
    parameter int unsigned CH_SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [31:0] BASE_ADDR      = magia_tile_pkg::IDMA_CTRL_ADDR_START,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter type obi_req_t              = magia_tile_pkg::obi_req_t,
    parameter type obi_rsp_t              = magia_tile_pkg::obi_rsp_t,
    parameter type idma_fe_reg_req_t      = magia_tile_pkg::idma_fe_reg_req_t,
    parameter type idma_fe_reg_rsp_t      = magia_tile_pkg::idma_fe_reg_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               test_en_i,
    input  obi_req_t                           obi_req_i,
    output obi_rsp_t                           obi_rsp_o,
    output idma_fe_reg_req_t [NUM_CH-1:0]      idma_fe_req_o,
    input  idma_fe_reg_rsp_t [NUM_CH-1:0]      idma_fe_rsp_i
);

    // Channel-select bits inside the 12-bit offset; they are not part of the register offset.
    localparam logic [11:0] CH_MASK = 12'(((32'd1 << CH_SEL_W) - 32'd1) << CH_SEL_OFF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FE_REQ = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e                r_state;
    logic [CH_SEL_W-1:0]   r_ch;
    logic [11:0]           r_off;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    obi_rsp_t              r_rsp;

    logic [CH_SEL_W-1:0]   w_ch;
    logic [11:0]           w_off_raw;
    logic [11:0]           w_off;
    logic                  w_hit;
    idma_fe_reg_rsp_t      w_sel_rsp;
    logic                  w_unused;

`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      r_tmo_cnt;
`endif

    // Register map of one reg32_3d frontend: base word, three 16-word blocks, and sparse 64-bit-spaced registers.
    function automatic logic f_off_legal(input logic [11:0] off);
        return (off == 12'h000) ||
               ((off[1:0] == 2'b00)  && (off >= 12'h004) && (off <= 12'h0C0)) ||
               ((off[2:0] == 3'b000) && (off >= 12'h0D0) && (off <= 12'h110));
    endfunction

    assign w_ch      = obi_req_i.a.addr[CH_SEL_OFF +: CH_SEL_W];
    assign w_off_raw = obi_req_i.a.addr[11:0] - BASE_ADDR[11:0];
    assign w_off     = w_off_raw & ~CH_MASK;
    assign w_hit     = f_off_legal(w_off) && (32'(w_ch) < NUM_CH);

    // Fields that carry no function in this bridge.
    assign w_unused  = ^{test_en_i, obi_req_i.a.addr[31:12], obi_req_i.a.a_optional, r_rsp.gnt};

    // Pick the response of the latched channel; other channels are never observed.
    always_comb begin
        w_sel_rsp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel_rsp = (r_ch == CH_SEL_W'(i)) ? idma_fe_rsp_i[i] : w_sel_rsp;
        end
    end

    // Drive only the latched channel while waiting on the frontend; all others stay at zero.
    always_comb begin
        idma_fe_req_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((r_state == S_FE_REQ) && (r_ch == CH_SEL_W'(i))) begin
                idma_fe_req_o[i].valid = 1'b1;
                idma_fe_req_o[i].addr  = {20'h00000, r_off};
                idma_fe_req_o[i].write = r_we;
                idma_fe_req_o[i].wdata = r_wdata;
                idma_fe_req_o[i].wstrb = r_be;
            end else begin
                idma_fe_req_o[i] = '0;
            end
        end
    end

    // Response channel is registered; only the grant follows the request combinationally in IDLE.
    always_comb begin
        obi_rsp_o     = r_rsp;
        obi_rsp_o.gnt = (r_state == S_IDLE) && obi_req_i.req;
    end

    // Control FSM: accept and latch an access, wait for the frontend, then answer once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_off     <= 12'h000;
            r_we      <= 1'b0;
            r_wdata   <= 32'h0000_0000;
            r_be      <= 4'h0;
            r_rsp     <= '0;
`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rsp.rvalid <= 1'b0;
                    if (obi_req_i.req) begin
                        r_ch        <= w_ch;
                        r_off       <= w_off;
                        r_we        <= obi_req_i.a.we;
                        r_wdata     <= obi_req_i.a.wdata;
                        r_be        <= obi_req_i.a.be;
                        r_rsp.r.rid <= obi_req_i.a.aid;
                        if (w_hit) begin
                            r_state <= S_FE_REQ;
                        end else begin
                            r_state       <= S_RESP;
                            r_rsp.rvalid  <= 1'b1;
                            r_rsp.r.rdata <= 32'h0000_0000;
                            r_rsp.r.err   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FE_REQ: begin
                    if (w_sel_rsp.ready) begin
                        r_state       <= S_RESP;
                        r_rsp.rvalid  <= 1'b1;
                        r_rsp.r.rdata <= r_we ? 32'h0000_0000 : w_sel_rsp.rdata;
                        r_rsp.r.err   <= w_sel_rsp.error;
`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
                        r_tmo_cnt     <= '0;
`endif
                    end
`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                        r_state       <= S_RESP;
                        r_rsp.rvalid  <= 1'b1;
                        r_rsp.r.rdata <= 32'h0000_0000;
                        r_rsp.r.err   <= 1'b1;
                        r_tmo_cnt     <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(32'd1);
                    end
`else
                    else begin
                        r_state <= S_FE_REQ;
                    end
`endif
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_rsp.rvalid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_rsp.rvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idma_obi_ctrl_mux.sv
// Self-checking bench for idma_obi_ctrl_mux: directed vector table, random
// accesses against a transaction-level reference model, and hand-written
// reset / long-wait sequences.
module tb_idma_obi_ctrl_mux;
    import magia_tile_pkg::*;

    localparam int unsigned NCH  = 2;
`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
    localparam int unsigned TMO  = 8;
`else
    localparam int unsigned TMO  = 256;
`endif
    localparam logic [31:0] BASE = IDMA_CTRL_ADDR_START;

    logic clk = 1'b0;
    logic rst_n;
    logic test_en;
    obi_req_t                     obi_req;
    obi_rsp_t                     obi_rsp;
    idma_fe_reg_req_t [NCH-1:0]   fe_req;
    idma_fe_reg_rsp_t [NCH-1:0]   fe_rsp;

    int checks   = 0;
    int failures = 0;
    bit legal_tbl [4096];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  aid;
        int          delay;
        logic [31:0] fe_rdata;
        logic        fe_err;
        logic        exp_hit;
        int          exp_ch;
        logic [11:0] exp_off;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    always #5 clk = ~clk;

    idma_obi_ctrl_mux #(
        .NUM_CH         (NCH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .test_en_i      (test_en),
        .obi_req_i      (obi_req),
        .obi_rsp_o      (obi_rsp),
        .idma_fe_req_o  (fe_req),
        .idma_fe_rsp_i  (fe_rsp)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_fe(input string name, input bit on, input int ch, input logic [11:0] off,
                          input logic we, input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i < NCH; i++) begin
            idma_fe_reg_req_t e;
            e = '0;
            if (on && (i == ch)) begin
                e.valid = 1'b1;
                e.addr  = {20'h00000, off};
                e.write = we;
                e.wdata = wd;
                e.wstrb = be;
            end
            chk($sformatf("%s fe%0d", name, i), 128'(fe_req[i]), 128'(e));
        end
    endtask

    function automatic vec_t mk(input logic [11:0] x, input logic we, input logic [31:0] wd,
                                input logic [3:0] be, input logic [3:0] aid, input int dly,
                                input logic [31:0] frd, input logic fer, input logic hit,
                                input int ch, input logic [11:0] off, input logic [31:0] erd,
                                input logic eer);
        vec_t v;
        v.addr = BASE + {20'h00000, x};
        v.we = we; v.wdata = wd; v.be = be; v.aid = aid; v.delay = dly;
        v.fe_rdata = frd; v.fe_err = fer;
        v.exp_hit = hit; v.exp_ch = ch; v.exp_off = off; v.exp_rdata = erd; v.exp_err = eer;
        return v;
    endfunction

    // One complete access starting in IDLE; request inputs are disturbed while the access is busy.
    task automatic run_txn(input vec_t v, input string tag);
        tick();
        obi_req.req          = 1'b1;
        obi_req.a.addr       = v.addr;
        obi_req.a.we         = v.we;
        obi_req.a.be         = v.be;
        obi_req.a.wdata      = v.wdata;
        obi_req.a.aid        = v.aid;
        obi_req.a.a_optional = 1'($urandom);
        fe_rsp = '0;
        #3;
        chk({tag, " gnt0"}, 128'(obi_rsp.gnt), 128'(1'b1));
        chk({tag, " rvalid0"}, 128'(obi_rsp.rvalid), 128'(1'b0));
        if (v.exp_hit) begin
            for (int c = 1; c <= v.delay; c++) begin
                tick();
                obi_req.req     = 1'($urandom);
                obi_req.a.addr  = $urandom;
                obi_req.a.we    = 1'($urandom);
                obi_req.a.be    = 4'($urandom);
                obi_req.a.wdata = $urandom;
                obi_req.a.aid   = 4'($urandom);
                fe_rsp = '0;
                fe_rsp[1 - v.exp_ch].ready = 1'($urandom);
                fe_rsp[1 - v.exp_ch].rdata = $urandom;
                fe_rsp[1 - v.exp_ch].error = 1'($urandom);
                if (c == v.delay) begin
                    fe_rsp[v.exp_ch].ready = 1'b1;
                    fe_rsp[v.exp_ch].rdata = v.fe_rdata;
                    fe_rsp[v.exp_ch].error = v.fe_err;
                end
                #3;
                chk($sformatf("%s gnt c%0d", tag, c), 128'(obi_rsp.gnt), 128'(1'b0));
                chk($sformatf("%s rvalid c%0d", tag, c), 128'(obi_rsp.rvalid), 128'(1'b0));
                chk_fe($sformatf("%s c%0d", tag, c), 1'b1, v.exp_ch, v.exp_off, v.we, v.wdata, v.be);
            end
        end
        tick();
        fe_rsp         = '0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = $urandom;
        #3;
        chk({tag, " rvalid"}, 128'(obi_rsp.rvalid), 128'(1'b1));
        chk({tag, " rdata"}, 128'(obi_rsp.r.rdata), 128'(v.exp_rdata));
        chk({tag, " err"}, 128'(obi_rsp.r.err), 128'(v.exp_err));
        chk({tag, " rid"}, 128'(obi_rsp.r.rid), 128'(v.aid));
        chk({tag, " ropt"}, 128'(obi_rsp.r.r_optional), 128'(1'b0));
        chk({tag, " gnt resp"}, 128'(obi_rsp.gnt), 128'(1'b0));
        chk_fe({tag, " resp"}, 1'b0, 0, 12'h000, 1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [14];
        vec_t v;

        legal_tbl[0] = 1'b1;
        for (int o = 4; o <= 'hC0; o += 4) legal_tbl[o] = 1'b1;
        for (int o = 'hD0; o <= 'h110; o += 8) legal_tbl[o] = 1'b1;

        //              x       we    wdata          be    aid  dly frdata         fer   hit  ch  off      erdata         eerr
        tbl[0]  = mk(12'h004, 1'b0, 32'h0,         4'hF, 4'h1, 1, 32'hCAFE0001, 1'b0, 1'b1, 0, 12'h004, 32'hCAFE0001, 1'b0);
        tbl[1]  = mk(12'h1D0, 1'b1, 32'h1000_0000, 4'hF, 4'h2, 5, 32'hFFFFFFFF, 1'b0, 1'b1, 1, 12'h0D0, 32'h0,         1'b0);
        tbl[2]  = mk(12'h0D4, 1'b0, 32'h0,         4'hF, 4'h3, 1, 32'h0,        1'b0, 1'b0, 0, 12'h0D4, 32'h0,         1'b1);
        tbl[3]  = mk(12'h140, 1'b1, 32'h5555AAAA,  4'h3, 4'h4, 2, 32'h11111111, 1'b1, 1'b1, 1, 12'h040, 32'h0,         1'b1);
        tbl[4]  = mk(12'h000, 1'b0, 32'h0,         4'hF, 4'h5, 3, 32'h12345678, 1'b0, 1'b1, 0, 12'h000, 32'h12345678, 1'b0);
        tbl[5]  = mk(12'h0C0, 1'b0, 32'h0,         4'hF, 4'h6, 1, 32'hDEADBEEF, 1'b1, 1'b1, 0, 12'h0C0, 32'hDEADBEEF, 1'b1);
        tbl[6]  = mk(12'h0C4, 1'b1, 32'h0,         4'hF, 4'h7, 1, 32'h0,        1'b0, 1'b0, 0, 12'h0C4, 32'h0,         1'b1);
        tbl[7]  = mk(12'h042, 1'b0, 32'h0,         4'hF, 4'h8, 1, 32'h0,        1'b0, 1'b0, 0, 12'h042, 32'h0,         1'b1);
        tbl[8]  = mk(12'h1F8, 1'b1, 32'hCAFEBABE,  4'hC, 4'h9, 4, 32'h0,        1'b0, 1'b1, 1, 12'h0F8, 32'h0,         1'b0);
        tbl[9]  = mk(12'h110, 1'b0, 32'h0,         4'hF, 4'hA, 2, 32'h0BADF00D, 1'b0, 1'b1, 1, 12'h010, 32'h0BADF00D, 1'b0);
        tbl[10] = mk(12'h0E4, 1'b0, 32'h0,         4'hF, 4'hB, 1, 32'h0,        1'b0, 1'b0, 0, 12'h0E4, 32'h0,         1'b1);
        tbl[11] = mk(12'h108, 1'b0, 32'h0,         4'hF, 4'hC, 7, 32'hA5A5A5A5, 1'b0, 1'b1, 1, 12'h008, 32'hA5A5A5A5, 1'b0);
        tbl[12] = mk(12'h1C0, 1'b0, 32'h0,         4'hF, 4'hD, 1, 32'h00000077, 1'b0, 1'b1, 1, 12'h0C0, 32'h00000077, 1'b0);
        tbl[13] = mk(12'h1D4, 1'b1, 32'h0,         4'hF, 4'hE, 1, 32'h0,        1'b0, 1'b0, 1, 12'h0D4, 32'h0,         1'b1);

        // Reset state
        rst_n   = 1'b0;
        test_en = 1'b0;
        obi_req = '0;
        fe_rsp  = '0;
        #12;
        chk("rst rvalid", 128'(obi_rsp.rvalid), 128'(1'b0));
        chk("rst rdata", 128'(obi_rsp.r.rdata), 128'(32'h0));
        chk("rst err", 128'(obi_rsp.r.err), 128'(1'b0));
        chk("rst rid", 128'(obi_rsp.r.rid), 128'(4'h0));
        chk_fe("rst", 1'b0, 0, 12'h000, 1'b0, 32'h0, 4'h0);
        chk("rst gnt idle", 128'(obi_rsp.gnt), 128'(1'b0));
        obi_req.req = 1'b1;
        #1;
        chk("rst gnt follows req", 128'(obi_rsp.gnt), 128'(1'b1));
        obi_req.req = 1'b0;
        #9;
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset while the frontend is being driven
        tick();
        obi_req = '0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = BASE + 32'h008;
        obi_req.a.aid  = 4'h3;
        fe_rsp = '0;
        #3;
        chk("arst gnt", 128'(obi_rsp.gnt), 128'(1'b1));
        tick();
        obi_req.req = 1'b0;
        #3;
        chk_fe("arst pre", 1'b1, 0, 12'h008, 1'b0, 32'h0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_fe("arst during", 1'b0, 0, 12'h000, 1'b0, 32'h0, 4'h0);
        chk("arst rvalid", 128'(obi_rsp.rvalid), 128'(1'b0));
        tick();
        rst_n = 1'b1;
        fe_rsp[0].ready = 1'b1;
        #3;
        chk("arst no resp", 128'(obi_rsp.rvalid), 128'(1'b0));
        chk_fe("arst after", 1'b0, 0, 12'h000, 1'b0, 32'h0, 4'h0);
        run_txn(tbl[0], "post-rst");

`ifdef IDMA_OBI_CTRL_TIMEOUT_EN
        // Frontend never ready: the watchdog abandons the access
        tick();
        obi_req = '0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = BASE + 32'h010;
        obi_req.a.aid  = 4'h6;
        fe_rsp = '0;
        #3;
        chk("tmo gnt", 128'(obi_rsp.gnt), 128'(1'b1));
        for (int c = 1; c <= TMO + 1; c++) begin
            tick();
            obi_req.req = 1'b0;
            #3;
            chk_fe($sformatf("tmo c%0d", c), 1'b1, 0, 12'h010, 1'b0, 32'h0, 4'h0);
            chk($sformatf("tmo rvalid c%0d", c), 128'(obi_rsp.rvalid), 128'(1'b0));
        end
        tick();
        #3;
        chk("tmo rvalid", 128'(obi_rsp.rvalid), 128'(1'b1));
        chk("tmo err", 128'(obi_rsp.r.err), 128'(1'b1));
        chk("tmo rdata", 128'(obi_rsp.r.rdata), 128'(32'h0));
        chk_fe("tmo resp", 1'b0, 0, 12'h000, 1'b0, 32'h0, 4'h0);
`else
        // Slow frontend: the access waits as long as it takes
        v = mk(12'h0E0, 1'b1, 32'h0F0F0F0F, 4'h5, 4'hF, 20, 32'h0, 1'b0, 1'b1, 0, 12'h0E0, 32'h0, 1'b0);
        run_txn(v, "long");
`endif

        // Random accesses against the transaction-level model
        test_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int unsigned r, a_lo, off, ch;
            logic [8:0]  x;
            logic [11:0] lo;
            r = $urandom_range(0, 3);
            x = 9'($urandom_range(0, 511));
            if (r < 2) x[1:0] = 2'b00;
            lo = BASE[11:0] + {3'b000, x};
            v.addr = (r == 3) ? $urandom : {20'($urandom), lo};
            v.we       = 1'($urandom);
            v.wdata    = $urandom;
            v.be       = 4'($urandom);
            v.aid      = 4'($urandom);
            v.delay    = $urandom_range(1, 6);
            v.fe_rdata = $urandom;
            v.fe_err   = ($urandom_range(0, 3) == 0);
            a_lo = v.addr & 32'hFFF;
            off  = (a_lo + 4096 - (BASE & 32'hFFF)) % 4096;
            ch   = (v.addr >> 8) % 2;
            off  = off & ~32'h100;
            v.exp_ch    = int'(ch);
            v.exp_off   = 12'(off);
            v.exp_hit   = legal_tbl[off] && (ch < NCH);
            v.exp_rdata = (v.exp_hit && !v.we) ? v.fe_rdata : 32'h0;
            v.exp_err   = v.exp_hit ? v.fe_err : 1'b1;
            run_txn(v, $sformatf("rnd%0d", n));
        end

        tick();
        obi_req.req = 1'b0;
        #3;
        chk("end rvalid", 128'(obi_rsp.rvalid), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
